// File: rtl/mips_pkg.sv
// Shared MIPS definitions: memory geometry, byte order and the instruction
// memory loader state encoding.
package mips_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int INSTR_W     = 32;

  // Stream bytes arrive most significant first, matching MIPS encoding.
  localparam bit BIG_ENDIAN  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_LOAD  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four stream bytes into one instruction word.
// word_o is the value that results from the shift presented this cycle.
module byte_packer
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [7:0]         byte_i,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_valid_o
);

  logic [INSTR_W-1:0] shreg_q;
  logic [1:0]         cnt_q;
  logic [INSTR_W-1:0] word_d;

  always_comb begin
    word_d = shreg_q;
    if (BIG_ENDIAN) begin
      word_d = {shreg_q[INSTR_W-9:0], byte_i};
    end else begin
      word_d = {byte_i, shreg_q[INSTR_W-1:8]};
    end
  end

  assign word_o       = word_d;
  assign word_valid_o = shift_i && (cnt_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= 2'd0;
    end else if (clear_i) begin
      shreg_q <= '0;
      cnt_q   <= 2'd0;
    end else if (shift_i) begin
      shreg_q <= word_d;
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a header-prefixed byte program into the instruction
// memory write port while holding the core. IMEM_LOADER_CHECKSUM_EN adds an XOR trailer check.
module imem_loader
  import mips_pkg::*;
#(
  parameter int                ADDR_W    = IMEM_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  WA,
  output logic [INSTR_W-1:0] WD,
  output logic               WE,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         dbg_state
);

  // Handshake: a byte moves when in_valid && in_ready at a rising edge;
  // in_ready depends only on state, never on in_valid.
  loader_state_e      state_q;
  logic               in_ready_q;
  logic [ADDR_W-1:0]  wa_q;
  logic [INSTR_W-1:0] wd_q;
  logic               we_q;
  logic               cpu_hold_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         wcnt_q;

  logic               xfer;
  logic               pk_clear;
  logic               pk_shift;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_word_valid;

  assign xfer     = in_valid && in_ready_q;
  assign pk_clear = (state_q == S_IDLE) && start;
  assign pk_shift = xfer && (state_q == S_LOAD);

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (pk_clear),
    .shift_i      (pk_shift),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;
  logic       err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      wa_q       <= BASE_ADDR;
      wd_q       <= '0;
      we_q       <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wcnt_q     <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= 8'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HDR;
            in_ready_q <= 1'b1;
            cpu_hold_q <= 1'b1;
            busy_q     <= 1'b1;
            wa_q       <= BASE_ADDR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
          end
        end
        S_HDR: begin
          if (xfer) begin
            wcnt_q  <= in_data;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q <= xor_q ^ in_data;
`endif
            if (pk_word_valid) begin
              wd_q       <= pk_word;
              we_q       <= 1'b1;
              in_ready_q <= 1'b0;
              state_q    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          wa_q <= wa_q + 1'b1;
          if (wcnt_q == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            in_ready_q <= 1'b1;
            state_q    <= S_CHK;
`else
            done_q     <= 1'b1;
            state_q    <= S_DONE;
`endif
          end else begin
            wcnt_q     <= wcnt_q - 8'd1;
            in_ready_q <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            // Error is reported only; the core is still released.
            err_q      <= (in_data != xor_q);
            in_ready_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          cpu_hold_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign WA        = wa_q;
  assign WD        = wd_q;
  assign WE        = we_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
